// File: rtl/cpu_pkg.sv
// Shared datapath constants: operand width, register addressing and
// symbolic register indices used by decode and the register file.
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADDR_W-1:0] R5 = 3'd5;
  localparam logic [ADDR_W-1:0] R6 = 3'd6;
  localparam logic [ADDR_W-1:0] R7 = 3'd7;
endpackage

// File: rtl/reg8.sv
// Single W-bit register with load enable and asynchronous active-high clear.
// Used for each operand register and, at width 1, for the zero flag.
module reg8 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end
endmodule

// File: rtl/reg_file.sv
// 8 x 8-bit operand register file: one clocked write port, two combinational
// read ports, plus a sticky ZERO flag captured from the ALU.
module reg_file
  import cpu_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  input  logic              ZERO_IN,
  input  logic              FLAGEN,
  output logic              ZFLAG
);
  logic [NREGS-1:0]  wr_sel;
  logic [DATA_W-1:0] regs [NREGS];

  // Each register decodes its own enable, so an unknown write address can
  // only disturb the entry whose compare is not a clean 0.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    assign wr_sel[gi] = WRITE & (INADDRESS == ADDR_W'(gi));

    reg8 #(.W(DATA_W)) u_reg (
      .clk (CLK),
      .rst (RESET),
      .en  (wr_sel[gi]),
      .d   (IN),
      .q   (regs[gi])
    );
  end

  // No write bypass: a same-cycle write shows up only after the edge.
  assign OUT1 = regs[OUT1ADDRESS];
  assign OUT2 = regs[OUT2ADDRESS];

  reg8 #(.W(1)) u_zflag (
    .clk (CLK),
    .rst (RESET),
    .en  (FLAGEN),
    .d   (ZERO_IN),
    .q   (ZFLAG)
  );
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read sweep, hold, same-address
// timing, zero flag and reset/write collision, with hand-computed expectations.
module tb_reg_file;
  import cpu_pkg::*;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [DATA_W-1:0] IN;
  logic [ADDR_W-1:0] INADDRESS;
  logic              WRITE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              ZERO_IN;
  logic              FLAGEN;
  logic              ZFLAG;

  int total = 0;
  int bad   = 0;

  reg_file dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN          (IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .OUT1        (OUT1),
    .OUT2        (OUT2),
    .ZERO_IN     (ZERO_IN),
    .FLAGEN      (FLAGEN),
    .ZFLAG       (ZFLAG)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%02h", tag, obs);
    end
  endtask

  // Drive a write at the falling edge; an unknown address is a stimulus error.
  task automatic drive_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(negedge CLK);
    if ($isunknown(addr)) begin
      total++;
      bad++;
      $display("FAIL stim_x_addr: got %b, want known address", addr);
    end
    INADDRESS = addr;
    IN        = data;
    WRITE     = 1'b1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1; IN = '0; INADDRESS = '0; WRITE = 1'b0;
    OUT1ADDRESS = '0; OUT2ADDRESS = '0; ZERO_IN = 1'b0; FLAGEN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out1", OUT1, 8'h00);
    check("rst_out2", OUT2, 8'h00);
    check("rst_zflag", {7'b0, ZFLAG}, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;

    // Load r3 and set the flag on the same edge, then clear both mid-cycle.
    drive_write(R3, 8'hAA);
    OUT1ADDRESS = R3;
    ZERO_IN = 1'b1; FLAGEN = 1'b1;
    tick();
    WRITE = 1'b0; FLAGEN = 1'b0; ZERO_IN = 1'b0;
    check("pre_rst_r3", OUT1, 8'hAA);
    check("pre_rst_zflag", {7'b0, ZFLAG}, 8'h01);
    #2 RESET = 1'b1;
    #1;
    check("midrst_r3", OUT1, 8'h00);
    check("midrst_zflag", {7'b0, ZFLAG}, 8'h00);
    RESET = 1'b0;

    // Write r_i = 0x10+i, then sweep both read ports in opposite directions.
    for (int i = 0; i < NREGS; i++) begin
      drive_write(ADDR_W'(i), 8'h10 + 8'(i));
      tick();
    end
    @(negedge CLK);
    WRITE = 1'b0;
    for (int a = 0; a < NREGS; a++) begin
      OUT1ADDRESS = ADDR_W'(a);
      OUT2ADDRESS = ADDR_W'(NREGS - 1 - a);
      #1;
      check($sformatf("sweep_out1_r%0d", a), OUT1, 8'h10 + 8'(a));
      check($sformatf("sweep_out2_r%0d", NREGS - 1 - a), OUT2, 8'h10 + 8'(NREGS - 1 - a));
    end

    // WRITE low for three edges must leave r5 alone.
    @(negedge CLK);
    IN = 8'hFF; INADDRESS = R5; WRITE = 1'b0; OUT1ADDRESS = R5;
    repeat (3) tick();
    check("hold_r5", OUT1, 8'h15);

    // Same-address read/write: old value before the edge, new after.
    drive_write(R2, 8'h5C);
    OUT1ADDRESS = R2; OUT2ADDRESS = R2;
    #1;
    check("same_pre_out1", OUT1, 8'h12);
    check("same_pre_out2", OUT2, 8'h12);
    tick();
    check("same_post_out1", OUT1, 8'h5C);
    check("same_post_out2", OUT2, 8'h5C);
    @(negedge CLK);
    WRITE = 1'b0;

    // Zero flag capture, hold and clear.
    ZERO_IN = 1'b1; FLAGEN = 1'b1;
    tick();
    check("flag_set", {7'b0, ZFLAG}, 8'h01);
    @(negedge CLK);
    ZERO_IN = 1'b0; FLAGEN = 1'b0;
    tick();
    check("flag_hold", {7'b0, ZFLAG}, 8'h01);
    @(negedge CLK);
    FLAGEN = 1'b1;
    tick();
    check("flag_clear", {7'b0, ZFLAG}, 8'h00);
    @(negedge CLK);
    FLAGEN = 1'b0;

    // Reset held across a write edge: the write is lost.
    drive_write(R4, 8'h77);
    RESET = 1'b1;
    OUT1ADDRESS = R4; OUT2ADDRESS = R2;
    tick();
    check("coll_r4", OUT1, 8'h00);
    check("coll_r2", OUT2, 8'h00);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("post_rst_pre_edge_r4", OUT1, 8'h00);
    tick();
    check("post_rst_r4", OUT1, 8'h77);
    check("post_rst_r2", OUT2, 8'h00);
    @(negedge CLK);
    WRITE = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
